// File: rtl/decimal_input_pkg.sv
// Shared definitions for the decimal keypad loader: key codes, display codes,
// slot count and FSM state encoding.
package decimal_input_pkg;

  localparam logic [3:0] KEY_MINUS = 4'd10;
  localparam logic [3:0] KEY_ENTER = 4'd11;
  localparam logic [3:0] KEY_CLEAR = 4'd12;
  localparam logic [3:0] KEY_NEXT  = 4'd13;

  localparam logic [3:0] BLANK = 4'd14;
  localparam logic [3:0] MINUS = 4'd15;

  localparam int NUM_SLOTS = 7;

  typedef enum logic [2:0] {
    ST_ENTRY = 3'd0,
    ST_CONV0 = 3'd1,
    ST_CONV1 = 3'd2,
    ST_CONV2 = 3'd3,
    ST_CHECK = 3'd4
  } state_t;

  // Slot numbers run 1..7 and wrap back to 1.
  function automatic logic [2:0] next_slot(input logic [2:0] slot);
    next_slot = (slot == 3'd7) ? 3'd1 : (slot + 3'd1);
  endfunction

endpackage

// File: rtl/decimal_mac.sv
// One decimal accumulate step: o_acc = i_acc*10 + i_digit, truncated to 10 bits.
module decimal_mac
  import decimal_input_pkg::*;
(
  input  logic [9:0] i_acc,
  input  logic [3:0] i_digit,
  output logic [9:0] o_acc
);

  logic [13:0] w_sum;

  // acc*10 as acc*8 + acc*2 avoids a generic multiplier.
  assign w_sum = {1'b0, i_acc, 3'b000} + {3'b000, i_acc, 1'b0} + {10'd0, i_digit};
  assign o_acc = w_sum[9:0];

endmodule

// File: rtl/decimal_input_loader.sv
// Keypad-driven loader: collects up to three decimal digits and a sign, converts
// them over three cycles, range-checks and writes one of seven 8-bit slots.
module decimal_input_loader
  import decimal_input_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic [7:0] indata1,
  output logic [7:0] indata2,
  output logic [7:0] indata3,
  output logic [7:0] indata4,
  output logic [7:0] indata5,
  output logic [7:0] indata6,
  output logic [7:0] indata7,
  output logic [2:0] slot_sel,
  output logic [3:0] disp_sign,
  output logic [3:0] disp_d3,
  output logic [3:0] disp_d2,
  output logic [3:0] disp_d1,
  output logic       entry_error,
  output logic       load_done
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_d3;
  logic [3:0]  r_d2;
  logic [3:0]  r_d1;
  logic [1:0]  r_count;
  logic        r_sign;
  logic        r_error;
  logic        r_load_done;
  logic [2:0]  r_slot_sel;
  logic [9:0]  r_acc;
  logic [7:0]  r_slot [NUM_SLOTS];

  logic        w_take;
  logic [3:0]  w_mac_digit;
  logic [9:0]  w_mac_acc;
  logic        w_accept;
  logic [7:0]  w_store;

  assign key_ready = (r_state == ST_ENTRY);
  assign w_take    = key_valid & key_ready;

  // Unentered digits are held as zero, so converting d3,d2,d1 in order is always correct.
  always_comb begin
    w_mac_digit = 4'd0;
    case (r_state)
      ST_CONV0: w_mac_digit = r_d3;
      ST_CONV1: w_mac_digit = r_d2;
      ST_CONV2: w_mac_digit = r_d1;
      default:  w_mac_digit = 4'd0;
    endcase
  end

  decimal_mac u_mac (
    .i_acc   (r_acc),
    .i_digit (w_mac_digit),
    .o_acc   (w_mac_acc)
  );

  assign w_accept = r_sign ? (r_acc <= 10'd128) : (r_acc <= 10'd127);
  assign w_store  = r_sign ? (~r_acc[7:0] + 8'd1) : r_acc[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_ENTRY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ENTRY: begin
        if (w_take && (key_code == KEY_ENTER)) begin
          w_state_nxt = ST_CONV0;
        end else begin
          w_state_nxt = ST_ENTRY;
        end
      end
      ST_CONV0: w_state_nxt = ST_CONV1;
      ST_CONV1: w_state_nxt = ST_CONV2;
      ST_CONV2: w_state_nxt = ST_CHECK;
      ST_CHECK: w_state_nxt = ST_ENTRY;
      default:  w_state_nxt = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_d3        <= 4'd0;
      r_d2        <= 4'd0;
      r_d1        <= 4'd0;
      r_count     <= 2'd0;
      r_sign      <= 1'b0;
      r_error     <= 1'b0;
      r_load_done <= 1'b0;
      r_slot_sel  <= 3'd1;
      r_acc       <= 10'd0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_slot[i] <= 8'd0;
      end
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        ST_ENTRY: begin
          if (w_take) begin
            if (key_code <= 4'd9) begin
              if (r_count < 2'd3) begin
                r_d3    <= r_d2;
                r_d2    <= r_d1;
                r_d1    <= key_code;
                r_count <= r_count + 2'd1;
              end else begin
                r_error <= 1'b1;
              end
            end else begin
              case (key_code)
                KEY_MINUS: r_sign <= ~r_sign;
                KEY_CLEAR: begin
                  r_d3    <= 4'd0;
                  r_d2    <= 4'd0;
                  r_d1    <= 4'd0;
                  r_count <= 2'd0;
                  r_sign  <= 1'b0;
                  r_error <= 1'b0;
                end
                KEY_NEXT: begin
                  r_d3       <= 4'd0;
                  r_d2       <= 4'd0;
                  r_d1       <= 4'd0;
                  r_count    <= 2'd0;
                  r_sign     <= 1'b0;
                  r_slot_sel <= next_slot(r_slot_sel);
                end
                KEY_ENTER: r_acc <= 10'd0;
                default: ;
              endcase
            end
          end
        end
        ST_CONV0, ST_CONV1, ST_CONV2: r_acc <= w_mac_acc;
        ST_CHECK: begin
          if (w_accept) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (r_slot_sel == 3'(i + 1)) begin
                r_slot[i] <= w_store;
              end
            end
            r_load_done <= 1'b1;
            r_slot_sel  <= next_slot(r_slot_sel);
          end else begin
            r_error <= 1'b1;
          end
          r_d3    <= 4'd0;
          r_d2    <= 4'd0;
          r_d1    <= 4'd0;
          r_count <= 2'd0;
          r_sign  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign indata1     = r_slot[0];
  assign indata2     = r_slot[1];
  assign indata3     = r_slot[2];
  assign indata4     = r_slot[3];
  assign indata5     = r_slot[4];
  assign indata6     = r_slot[5];
  assign indata7     = r_slot[6];
  assign slot_sel    = r_slot_sel;
  assign entry_error = r_error;
  assign load_done   = r_load_done;

  assign disp_sign = r_sign ? MINUS : BLANK;
  assign disp_d3   = (r_count == 2'd3) ? r_d3 : BLANK;
  assign disp_d2   = (r_count >= 2'd2) ? r_d2 : BLANK;
  assign disp_d1   = (r_count >= 2'd1) ? r_d1 : BLANK;

endmodule
